// File: rtl/wisc_pkg.sv
// Shared definitions for the 16-bit WISC pipeline front end.
//   WORD_W        : datapath word width
//   OP_HLT        : opcode [15:12] of the halt instruction
//   fetch_state_t : fetch FSM state encoding
//   is_hlt()      : true when an instruction word carries the HLT opcode
package wisc_pkg;

    localparam int WORD_W = 16;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        REQ  = 2'd0,
        WAIT = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    function automatic logic is_hlt(input word_t instr);
        return instr[WORD_W-1 -: 4] == OP_HLT;
    endfunction

endpackage

// File: rtl/if_slot.sv
// One registered fetch entry {valid, instr, pc, pc2}.
// Ports:
//   clk, rst_n        : clock, async active-low reset
//   load              : capture d_* and set valid
//   clear             : drop valid (wins over load)
//   d_instr/d_pc/d_pc2: entry contents to capture
//   valid/instr/pc/pc2: registered entry
module if_slot
    import wisc_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  load,
    input  logic  clear,
    input  word_t d_instr,
    input  word_t d_pc,
    input  word_t d_pc2,
    output logic  valid,
    output word_t instr,
    output word_t pc,
    output word_t pc2
);

    logic  valid_q, valid_d;
    word_t instr_q, instr_d;
    word_t pc_q,    pc_d;
    word_t pc2_q,   pc2_d;

    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        pc2_d   = pc2_q;
        if (clear) begin
            // Payload is left stale; only valid qualifies it.
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            instr_d = d_instr;
            pc_d    = d_pc;
            pc2_d   = d_pc2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
            pc2_q   <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
            pc2_q   <= pc2_d;
        end
    end

    assign valid = valid_q;
    assign instr = instr_q;
    assign pc    = pc_q;
    assign pc2   = pc2_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: one outstanding imem request at a time, a
// two-deep delivery buffer (output slot + hold buffer) towards decode,
// flush/redirect handling and HLT detection.
//
// state | meaning
// ------+-----------------------------------------------------------
// REQ   | may issue a request (unless flushing or hold buffer full)
// WAIT  | one request outstanding, waiting for imem_rvalid
// HALT  | HLT fetched; idle until flush or reset
//
// Ports:
//   clk, rst_n                 : clock, async active-low reset
//   pc_in                      : current PC from the PC block
//   pc_adv                     : PC register write enable (request accepted)
//   imem_req/imem_addr         : instruction memory request and address
//   imem_ready                 : memory accepts the request this cycle
//   imem_rvalid/imem_rdata     : returned instruction word
//   flush                      : redirect; kills all in-flight fetch state
//   stall                      : decode cannot accept this cycle
//   if_valid/if_instr/if_pc/if_pc2 : fetched instruction to decode
//   halted                     : FSM is in HALT
module fetch_stage
    import wisc_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  word_t pc_in,
    output logic  pc_adv,
    output logic  imem_req,
    output word_t imem_addr,
    input  logic  imem_ready,
    input  logic  imem_rvalid,
    input  word_t imem_rdata,
    input  logic  flush,
    input  logic  stall,
    output logic  if_valid,
    output word_t if_instr,
    output word_t if_pc,
    output word_t if_pc2,
    output logic  halted
);

    fetch_state_t state_q, state_d;
    word_t        pend_pc_q, pend_pc_d;
    logic         discard_q, discard_d;

    logic  hold_v;
    word_t hold_instr, hold_pc, hold_pc2;

    logic  consume;
    logic  rsp;
    logic  rsp_keep;
    logic  accept;
    logic  out_from_hold;
    logic  out_from_rsp;
    logic  out_load;
    logic  out_clear;
    logic  hold_load;
    logic  hold_clear;
    word_t out_d_instr, out_d_pc, out_d_pc2;
    word_t rsp_pc2;

    assign imem_addr = pc_in;
    assign halted    = (state_q == HALT);
    assign rsp_pc2   = pend_pc_q + word_t'(2);

    // Request side. stall never gates the request: backpressure is only
    // through the hold buffer, which caps buffered instructions at two.
    always_comb begin
        imem_req = (state_q == REQ) && !flush && !hold_v;
        accept   = imem_req && imem_ready;
        pc_adv   = accept;
    end

    // Response routing between the output slot and the hold buffer.
    always_comb begin
        consume  = if_valid && !stall;
        rsp      = (state_q == WAIT) && imem_rvalid;
        rsp_keep = rsp && !discard_q && !flush;

        out_from_hold = !flush && consume && hold_v;
        out_from_rsp  = rsp_keep && !out_from_hold && (!if_valid || consume);
        out_load      = out_from_hold || out_from_rsp;
        out_clear     = flush || (consume && !out_load);

        // A kept response that the output slot cannot take goes to hold;
        // this also covers hold being promoted and refilled in one cycle.
        hold_load  = rsp_keep && !out_from_rsp;
        hold_clear = flush || (out_from_hold && !hold_load);

        if (out_from_hold) begin
            out_d_instr = hold_instr;
            out_d_pc    = hold_pc;
            out_d_pc2   = hold_pc2;
        end else begin
            out_d_instr = imem_rdata;
            out_d_pc    = pend_pc_q;
            out_d_pc2   = rsp_pc2;
        end
    end

    // Discard tracks a request that was outstanding when a flush hit; its
    // response is dropped when it arrives. A flush coinciding with the
    // response drops the data directly and leaves nothing to discard.
    always_comb begin
        discard_d = discard_q;
        if (rsp) begin
            discard_d = 1'b0;
        end
        if (flush && (state_q == WAIT) && !imem_rvalid) begin
            discard_d = 1'b1;
        end
    end

    always_comb begin
        state_d   = state_q;
        pend_pc_d = pend_pc_q;
        if (accept) begin
            pend_pc_d = pc_in;
        end
        case (state_q)
            REQ: begin
                if (accept) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // A flush without rvalid keeps us here: the request is
                // still outstanding and must be drained before reissuing.
                if (imem_rvalid) begin
                    if (rsp_keep && is_hlt(imem_rdata)) begin
                        state_d = HALT;
                    end else begin
                        state_d = REQ;
                    end
                end
            end
            HALT: begin
                if (flush) begin
                    state_d = REQ;
                end
            end
            default: begin
                state_d = REQ;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= REQ;
            pend_pc_q <= '0;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend_pc_q <= pend_pc_d;
            discard_q <= discard_d;
        end
    end

    if_slot u_out_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (out_load),
        .clear   (out_clear),
        .d_instr (out_d_instr),
        .d_pc    (out_d_pc),
        .d_pc2   (out_d_pc2),
        .valid   (if_valid),
        .instr   (if_instr),
        .pc      (if_pc),
        .pc2     (if_pc2)
    );

    if_slot u_hold_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (hold_load),
        .clear   (hold_clear),
        .d_instr (imem_rdata),
        .d_pc    (pend_pc_q),
        .d_pc2   (rsp_pc2),
        .valid   (hold_v),
        .instr   (hold_instr),
        .pc      (hold_pc),
        .pc2     (hold_pc2)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios followed by random traffic.
// The bench acts as PC block and instruction memory; every response it
// returns that survives flushes is queued as the expected delivery.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] pc_in = '0;
    logic        pc_adv;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [15:0] imem_rdata = '0;
    logic        flush = 1'b0;
    logic        stall = 1'b0;
    logic        if_valid;
    logic [15:0] if_instr;
    logic [15:0] if_pc;
    logic [15:0] if_pc2;
    logic        halted;

    fetch_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc_in       (pc_in),
        .pc_adv      (pc_adv),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .flush       (flush),
        .stall       (stall),
        .if_valid    (if_valid),
        .if_instr    (if_instr),
        .if_pc       (if_pc),
        .if_pc2      (if_pc2),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] pc;
        logic [15:0] pc2;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   n_pop = 0;

    // environment / model state
    logic [15:0] pc_model = '0;
    logic        adv_seen = 1'b0;
    logic        exp_halted = 1'b0;
    logic        halt_nxt = 1'b0;
    logic        m_pend = 1'b0;
    logic        m_kill = 1'b0;
    int          m_lat = 0;
    logic [15:0] m_addr = '0;

    // stimulus controls
    logic        rnd = 1'b0;
    logic        c_stall = 1'b0;
    logic        c_ready = 1'b1;
    logic        c_flush = 1'b0;
    logic        hlt_en = 1'b0;
    int          force_lat = 0;
    logic        force_word_v = 1'b0;
    logic [15:0] force_word = '0;
    logic        redirect_v = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        stray_once = 1'b0;

    // samples taken at the falling edge of the last tick
    logic        s_req, s_adv, s_valid, s_halted;
    logic [15:0] s_addr, s_instr, s_pc, s_pc2;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: checks every delivered instruction against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (imem_req) check("imem_addr", imem_addr, pc_model);
            check("pc_adv", {15'd0, pc_adv}, {15'd0, imem_req && imem_ready});
            check("halted", {15'd0, halted}, {15'd0, exp_halted});
            if (exp_halted) check("req_while_halted", {15'd0, imem_req}, 16'd0);
            if (if_valid && !stall && !flush) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: got instr %h pc %h, expected nothing", if_instr, if_pc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    n_pop++;
                    check("if_instr", if_instr, e.instr);
                    check("if_pc", if_pc, e.pc);
                    check("if_pc2", if_pc2, e.pc2);
                end
            end
            if (flush) sb.delete();
            check("buffer_depth_ok", {15'd0, sb.size() <= 2}, 16'd1);
        end
    end

    // One clock cycle, entered and left just after the rising edge.
    task automatic tick();
        logic        fl;
        logic [15:0] w;
        exp_t        e;
        exp_halted = halt_nxt;
        if (adv_seen) pc_model = pc_model + 16'd2;
        adv_seen = 1'b0;

        fl = c_flush || (rnd && ($urandom_range(99) < (exp_halted ? 20 : 3)));
        c_flush = 1'b0;
        if (fl && rnd && ($urandom_range(1) == 1)) pc_model = 16'($urandom) & 16'hFFFE;
        if (fl && redirect_v) begin
            pc_model = redirect_pc;
            redirect_v = 1'b0;
        end

        stall      = rnd ? ($urandom_range(99) < 30) : c_stall;
        imem_ready = rnd ? ($urandom_range(99) < 70) : c_ready;
        flush      = fl;
        pc_in      = pc_model;
        imem_rvalid = 1'b0;
        imem_rdata  = 16'($urandom);
        halt_nxt    = exp_halted;

        if (m_pend) begin
            if (m_lat == 0) begin
                if (force_word_v) begin
                    w = force_word;
                    force_word_v = 1'b0;
                end else begin
                    w = 16'($urandom);
                    if (!hlt_en && w[15:12] == 4'hF) w[15:12] = 4'hE;
                end
                imem_rvalid = 1'b1;
                imem_rdata  = w;
                m_pend = 1'b0;
                if (!m_kill && !fl) begin
                    e.instr = w;
                    e.pc    = m_addr;
                    e.pc2   = m_addr + 16'd2;
                    sb.push_back(e);
                    if (w[15:12] == 4'hF) halt_nxt = 1'b1;
                end
            end else begin
                m_lat--;
                if (fl) m_kill = 1'b1;
            end
        end else if (stray_once || (rnd && $urandom_range(99) < 10)) begin
            imem_rvalid = 1'b1;
            stray_once = 1'b0;
        end
        if (fl) halt_nxt = 1'b0;

        @(negedge clk);
        s_req    = imem_req;
        s_adv    = pc_adv;
        s_addr   = imem_addr;
        s_valid  = if_valid;
        s_instr  = if_instr;
        s_pc     = if_pc;
        s_pc2    = if_pc2;
        s_halted = halted;
        if (pc_adv) begin
            m_pend   = 1'b1;
            m_kill   = 1'b0;
            m_addr   = pc_model;
            m_lat    = (force_lat >= 0) ? force_lat : int'($urandom_range(2));
            adv_seen = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_adv(input string name);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!s_adv && n < 30);
        check(name, {15'd0, s_adv}, 16'd1);
    endtask

    task automatic do_reset(input logic [15:0] new_pc);
        rst_n = 1'b0;
        #1;
        check("rst_if_valid", {15'd0, if_valid}, 16'd0);
        check("rst_if_instr", if_instr, 16'd0);
        check("rst_if_pc", if_pc, 16'd0);
        check("rst_if_pc2", if_pc2, 16'd0);
        check("rst_halted", {15'd0, halted}, 16'd0);
        sb.delete();
        m_pend = 1'b0;
        m_kill = 1'b0;
        adv_seen = 1'b0;
        halt_nxt = 1'b0;
        exp_halted = 1'b0;
        pc_model = new_pc;
        pc_in = new_pc;
        flush = 1'b0;
        stall = 1'b0;
        imem_rvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        // reset, then 1-cycle memory with no stall
        @(posedge clk);
        #1;
        do_reset(16'h0000);
        force_word = 16'h1111;
        force_word_v = 1'b1;
        tick();
        check("first_req", {15'd0, s_req}, 16'd1);
        check("first_adv", {15'd0, s_adv}, 16'd1);
        check("first_addr", s_addr, 16'h0000);
        tick();
        check("no_req_in_wait", {15'd0, s_req}, 16'd0);
        check("valid_not_yet", {15'd0, s_valid}, 16'd0);
        tick();
        check("first_valid", {15'd0, s_valid}, 16'd1);
        check("first_pc", s_pc, 16'h0000);
        check("first_pc2", s_pc2, 16'h0002);
        check("first_instr", s_instr, 16'h1111);
        check("second_req", {15'd0, s_req}, 16'd1);

        // stall held for 6 cycles: two buffered, then requests stop
        begin
            int n0;
            c_stall = 1'b1;
            repeat (4) tick();
            tick();
            check("stall_req_off_a", {15'd0, s_req}, 16'd0);
            tick();
            check("stall_req_off_b", {15'd0, s_req}, 16'd0);
            n0 = n_pop;
            c_stall = 1'b0;
            repeat (2) tick();
            check("stall_release_cnt", 16'(n_pop - n0), 16'd2);
        end

        // flush while waiting on 0x1234; next request at 0x0040
        force_lat = 3;
        wait_adv("adv_before_flush");
        force_word = 16'h1234;
        force_word_v = 1'b1;
        c_flush = 1'b1;
        redirect_pc = 16'h0040;
        redirect_v = 1'b1;
        force_lat = 0;
        tick();
        wait_adv("adv_after_flush");
        check("redirect_addr", s_addr, 16'h0040);

        // HLT fetch
        force_word = 16'hF000;
        force_word_v = 1'b1;
        tick();
        tick();
        check("hlt_valid", {15'd0, s_valid}, 16'd1);
        check("hlt_instr", s_instr, 16'hF000);
        check("hlt_halted", {15'd0, s_halted}, 16'd1);
        repeat (5) begin
            tick();
            check("hlt_no_req", {15'd0, s_req}, 16'd0);
        end
        c_flush = 1'b1;
        redirect_pc = 16'hFFFE;
        redirect_v = 1'b1;
        tick();
        tick();
        check("unhalt_halted", {15'd0, s_halted}, 16'd0);
        check("unhalt_req", {15'd0, s_req}, 16'd1);
        check("unhalt_addr", s_addr, 16'hFFFE);

        // pc2 wrap
        tick();
        tick();
        check("wrap_valid", {15'd0, s_valid}, 16'd1);
        check("wrap_pc", s_pc, 16'hFFFE);
        check("wrap_pc2", s_pc2, 16'h0000);

        // reset mid-WAIT, then stray rvalid
        force_lat = 3;
        wait_adv("adv_before_reset");
        tick();
        #2;
        do_reset(16'h0100);
        force_lat = 0;
        stray_once = 1'b1;
        c_ready = 1'b0;
        tick();
        check("stray_valid_a", {15'd0, s_valid}, 16'd0);
        c_ready = 1'b1;
        tick();
        check("stray_valid_b", {15'd0, s_valid}, 16'd0);
        check("post_rst_adv", {15'd0, s_adv}, 16'd1);
        check("post_rst_addr", s_addr, 16'h0100);

        // random traffic
        rnd = 1'b1;
        force_lat = -1;
        hlt_en = 1'b1;
        repeat (3000) tick();

        // drain
        rnd = 1'b0;
        hlt_en = 1'b0;
        c_stall = 1'b0;
        c_ready = 1'b1;
        c_flush = 1'b1;
        tick();
        repeat (12) tick();
        check("drain_empty", 16'(sb.size()), 16'd0);
        check("delivered_enough", {15'd0, n_pop > 100}, 16'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
